// File: rtl/cn_change_tx_if.sv
// Bus bundle for cn_change_tx: monitored vector and force request in,
// serial line and frame status out.
interface cn_change_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             force_send;
    logic             tx;
    logic             busy;
    logic             done;
    logic [7:0]       frame_cnt;

    modport master (
        output d,
        output force_send,
        input  tx,
        input  busy,
        input  done,
        input  frame_cnt
    );

    modport slave (
        input  d,
        input  force_send,
        output tx,
        output busy,
        output done,
        output frame_cnt
    );
endinterface

// File: rtl/cn_change_tx.sv
// Change-only serial transmitter: start bit, LSB-first data, optional even
// parity (define CN_TX_PARITY_EN), stop bit; coalesces changes made mid-frame.
module cn_change_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic          clk,
    input  logic          reset,
    cn_change_tx_if.slave bus
);
    localparam int DW = $clog2(DIV);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] last_sent_q, last_sent_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             div_last;

`ifdef CN_TX_PARITY_EN
    logic parity_q, parity_d;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    // Next-state logic; outputs are derived from the current state so the
    // line lags the FSM by one clock and never sees d combinationally.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        last_sent_d = last_sent_q;
`ifdef CN_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        div_last    = (div_cnt_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                div_cnt_d = {DW{1'b0}};
                bit_cnt_d = {BW{1'b0}};
                if ((bus.d != last_sent_q) || bus.force_send) begin
                    shift_d     = bus.d;
                    last_sent_d = bus.d;
`ifdef CN_TX_PARITY_EN
                    parity_d    = even_parity(bus.d);
`endif
                    state_d     = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (div_last) begin
                    div_cnt_d = {DW{1'b0}};
                    state_d   = S_DATA;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (div_last) begin
                    div_cnt_d = {DW{1'b0}};
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = {BW{1'b0}};
`ifdef CN_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`ifdef CN_TX_PARITY_EN
            S_PARITY: begin
                if (div_last) begin
                    div_cnt_d = {DW{1'b0}};
                    state_d   = S_STOP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (div_last) begin
                    div_cnt_d = {DW{1'b0}};
                    state_d   = S_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: begin
                div_cnt_d = {DW{1'b0}};
                bit_cnt_d = {BW{1'b0}};
                state_d   = S_IDLE;
            end
        endcase

        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef CN_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase

        busy_d      = (state_q != S_IDLE);
        done_d      = (state_q == S_STOP) && div_last;
        frame_cnt_d = done_d ? (frame_cnt_q + 8'd1) : frame_cnt_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (reset == 1'b0) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= {DW{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            shift_q     <= {WIDTH{1'b0}};
            last_sent_q <= {WIDTH{1'b0}};
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= 8'd0;
`ifdef CN_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            last_sent_q <= last_sent_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CN_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: doc/cn_change_tx.md
# cn_change_tx

Serial change-notification transmitter, the sending end of the change-only capture path. It watches a WIDTH-bit input vector and compares it against the last value it sent. When the two differ, it snapshots the input and transmits it as a framed, LSB-first serial word on a single wire. Changes that occur while a frame is in flight are coalesced, so only the latest value is sent once the line is free.

## Interface
- `WIDTH`, 8: width of the monitored vector (1..32).
- `DIV`, 4: clocks per serial bit (>=2).

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `d`  in  WIDTH  monitored vector; synchronous to `clk`.
- `force_send`  in  1  request to transmit `d` even if unchanged; sampled only in IDLE.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress (START..STOP).
- `done`  out  1  one-cycle pulse in the final clock of the STOP bit.
- `frame_cnt`  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- Internal state:
  - `last_sent[WIDTH]` holds the last transmitted value.
  - `shift[WIDTH]` holds the frame snapshot.
  - `div_cnt` counts 0..DIV-1.
  - `bit_cnt` counts 0..WIDTH-1.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - If `d != last_sent` or `force_send`: `shift <= d`, `last_sent <= d`, go to START.
  - Otherwise stay in IDLE.
- START: drive `tx` = 0 for DIV clocks, then go to DATA.
- DATA:
  - Drive `tx` = `shift[0]` for DIV clocks, then shift right and increment `bit_cnt`.
  - After bit WIDTH-1, go to PARITY if enabled, else STOP.
- STOP:
  - Drive `tx` = 1 for DIV clocks.
  - Pulse `done` on the last clock and increment `frame_cnt`, then go to IDLE.
- Changes on `d` during START..STOP are not sampled. Only the value present in the first IDLE cycle after STOP is compared (coalescing).
- A change that reverts to `last_sent` before the comparison produces no frame.
- `tx`, `busy` and `done` are registered outputs, with no combinational path from `d`.

## Timing
- Reset values:
  - `tx` = 1, `busy` = 0, `done` = 0, `frame_cnt` = 0.
  - `last_sent` = 0, state = IDLE.
- Latency: change sampled at edge k; `tx` falls and `busy` rises after edge k+1.
- Frame length: (WIDTH+2)*DIV clocks, or (WIDTH+3)*DIV with parity. `busy` is high for exactly that many cycles.
- `done` is high in the same cycle as the last STOP clock. `busy` drops on the following edge.
- Back-to-back frames: at least one IDLE cycle (`tx` = 1, `busy` = 0) separates frames. The next START begins one cycle after `busy` falls if a difference exists.
- `force_send` with `d == last_sent` sends a frame carrying the unchanged value. `force_send` is ignored while `busy`.
- Reset asserted mid-frame:
  - On the next edge, the FSM returns to IDLE and `tx` = 1; no `done` pulse.
  - `last_sent` and `frame_cnt` are cleared.
  - The first IDLE cycle after reset releases sends a frame if `d != 0`.
- `frame_cnt` increments modulo 256 and is never saturated.

## Configuration
- `CN_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - `tx` carries the even parity of the snapshot (XOR of all WIDTH bits) for DIV clocks.
- Not defined: no parity bit; frame is start, data, stop only.

## Test plan
- Reset with `d` = 0, release, hold 20 cycles -> `tx` stays 1, `busy` 0, no `done`, `frame_cnt` 0.
- `d` 0x00 -> 0xA5 (WIDTH=8, DIV=4) -> `tx` reads 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 clocks. `busy` high 40 cycles, `done` on cycle 40, `frame_cnt` = 1. With parity: bit 0 inserted, 44 cycles.
- During the 0xA5 frame, change `d` to 0x3C, then 0x5A -> a single following frame carries 0x5A after 1 idle cycle. 0x3C is never sent.
- During a frame, `d` changes away and back to the value being sent -> no second frame.
- Assert `force_send` for one IDLE cycle with `d` = `last_sent` = 0x5A -> one frame of 0x5A. Assert `force_send` while `busy` -> ignored.
- Assert `reset` (low) in DATA bit 3 -> next edge `tx` = 1, `busy` = 0, `frame_cnt` = 0. Release with `d` = 0x5A -> a new full frame of 0x5A.
- Send 256 frames -> `frame_cnt` wraps to 0.
